// File: rtl/control_sequencer.sv
// Multi-cycle instruction sequencer driving every datapath control input from registers.
// Optional macro SINGLE_STEP_EN adds a step input that gates each FETCH.
module control_sequencer #(
    parameter logic [3:0]  ALU_PASS_OP = 4'hF,
    parameter int unsigned IMM_WIDTH   = 8
) (
    input  logic        clock,
    input  logic        reset,
`ifdef SINGLE_STEP_EN
    input  logic        step,
`endif
    input  logic [15:0] current_instruction,
    input  logic [15:0] zeroflag,
    output logic        program_counter_increment,
    output logic [3:0]  alu_op,
    output logic [15:0] alu_a_altern,
    output logic [15:0] alu_b_altern,
    output logic [3:0]  alu_a_select,
    output logic [3:0]  alu_b_select,
    output logic        alu_a_source,
    output logic        alu_b_source,
    output logic [3:0]  alu_out_select,
    output logic [1:0]  alu_load_src,
    output logic        alu_store_to_mem,
    output logic        alu_store_to_stk,
    output logic [3:0]  vga_color_select,
    output logic [3:0]  vga_coord_select,
    output logic        plot,
    output logic        halted,
    output logic [15:0] retired
);

    typedef enum logic [1:0] {StFetch, StExec, StMemwait, StHalted} state_e;

    localparam logic [3:0] OpLoadi = 4'h8;
    localparam logic [3:0] OpLd    = 4'h9;
    localparam logic [3:0] OpLds   = 4'hA;
    localparam logic [3:0] OpSt    = 4'hB;
    localparam logic [3:0] OpSts   = 4'hC;
    localparam logic [3:0] OpBrz   = 4'hD;
    localparam logic [3:0] OpPlot  = 4'hE;
    localparam logic [3:0] OpHalt  = 4'hF;

    state_e      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] retired_d;
    logic        advance;

    logic        inc_d, a_source_d, store_mem_d, store_stk_d, plot_d, halted_d;
    logic [3:0]  alu_op_d, a_select_d, b_select_d, out_select_d, color_d, coord_d;
    logic [1:0]  load_src_d;
    logic [15:0] a_altern_d;
    logic [3:0]  op, fd, fa, fb;

`ifdef SINGLE_STEP_EN
    assign advance = step;
`else
    assign advance = 1'b1;
`endif

    // Outputs are decoded for the state being entered so they are registered
    // and settled a half cycle before the datapath commits on the negedge.
    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        retired_d    = retired_q_int();
        inc_d        = 1'b0;
        a_source_d   = 1'b0;
        store_mem_d  = 1'b0;
        store_stk_d  = 1'b0;
        plot_d       = 1'b0;
        alu_op_d     = 4'h0;
        a_select_d   = 4'h0;
        b_select_d   = 4'h0;
        out_select_d = 4'h0;
        color_d      = 4'h0;
        coord_d      = 4'h0;
        load_src_d   = 2'b00;
        a_altern_d   = 16'h0000;

        case (state_q)
            StFetch: begin
                if (advance) begin
                    ir_d    = current_instruction;
                    state_d = StExec;
                end
            end
            StExec: begin
                if (ir_q[15:12] == OpLd || ir_q[15:12] == OpLds) begin
                    state_d = StMemwait;
                end else if (ir_q[15:12] == OpHalt) begin
                    state_d = StHalted;
                end else begin
                    state_d   = StFetch;
                    retired_d = retired + 16'd1;
                end
            end
            StMemwait: begin
                state_d   = StFetch;
                retired_d = retired + 16'd1;
            end
            default: state_d = StHalted;
        endcase

        op = ir_d[15:12];
        fd = ir_d[11:8];
        fa = ir_d[7:4];
        fb = ir_d[3:0];

        if (state_d == StExec) begin
            unique case (op)
                4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                    alu_op_d     = {1'b0, op[2:0]};
                    a_select_d   = fa;
                    b_select_d   = fb;
                    out_select_d = fd;
                    load_src_d   = 2'b01;
                    inc_d        = 1'b1;
                end
                OpLoadi: begin
                    alu_op_d     = ALU_PASS_OP;
                    a_source_d   = 1'b1;
                    a_altern_d   = 16'(ir_d[IMM_WIDTH-1:0]);
                    out_select_d = fd;
                    load_src_d   = 2'b01;
                    inc_d        = 1'b1;
                end
                OpLd, OpLds: begin
                    alu_op_d     = ALU_PASS_OP;
                    a_select_d   = fa;
                    out_select_d = fd;
                end
                OpSt, OpSts: begin
                    alu_op_d     = ALU_PASS_OP;
                    a_select_d   = fa;
                    out_select_d = fd;
                    store_mem_d  = (op == OpSt);
                    store_stk_d  = (op == OpSts);
                    inc_d        = 1'b1;
                end
                OpBrz: begin
                    // Taken branch writes rb straight into r0; no increment on top.
                    if (zeroflag[fa]) begin
                        alu_op_d   = ALU_PASS_OP;
                        a_select_d = fb;
                        b_select_d = fb;
                        load_src_d = 2'b01;
                    end else begin
                        inc_d = 1'b1;
                    end
                end
                OpPlot: begin
                    plot_d  = 1'b1;
                    color_d = fd;
                    coord_d = fa;
                    inc_d   = 1'b1;
                end
                OpHalt: begin
                end
            endcase
        end else if (state_d == StMemwait) begin
            alu_op_d     = ALU_PASS_OP;
            a_select_d   = fa;
            out_select_d = fd;
            load_src_d   = (op == OpLds) ? 2'b11 : 2'b10;
            inc_d        = 1'b1;
        end

        halted_d = (state_d == StHalted);
    end

    function automatic logic [15:0] retired_q_int();
        return retired;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q                   <= StFetch;
            ir_q                      <= 16'h0000;
            retired                   <= 16'h0000;
            program_counter_increment <= 1'b0;
            alu_op                    <= 4'h0;
            alu_a_altern              <= 16'h0000;
            alu_b_altern              <= 16'h0000;
            alu_a_select              <= 4'h0;
            alu_b_select              <= 4'h0;
            alu_a_source              <= 1'b0;
            alu_b_source              <= 1'b0;
            alu_out_select            <= 4'h0;
            alu_load_src              <= 2'b00;
            alu_store_to_mem          <= 1'b0;
            alu_store_to_stk          <= 1'b0;
            vga_color_select          <= 4'h0;
            vga_coord_select          <= 4'h0;
            plot                      <= 1'b0;
            halted                    <= 1'b0;
        end else begin
            state_q                   <= state_d;
            ir_q                      <= ir_d;
            retired                   <= retired_d;
            program_counter_increment <= inc_d;
            alu_op                    <= alu_op_d;
            alu_a_altern              <= a_altern_d;
            alu_b_altern              <= 16'h0000;
            alu_a_select              <= a_select_d;
            alu_b_select              <= b_select_d;
            alu_a_source              <= a_source_d;
            alu_b_source              <= 1'b0;
            alu_out_select            <= out_select_d;
            alu_load_src              <= load_src_d;
            alu_store_to_mem          <= store_mem_d;
            alu_store_to_stk          <= store_stk_d;
            vga_color_select          <= color_d;
            vga_coord_select          <= coord_d;
            plot                      <= plot_d;
            halted                    <= halted_d;
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer; build with SINGLE_STEP_EN to
// also exercise the step gate.
module tb_control_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] current_instruction = 16'h0000;
    logic [15:0] zeroflag = 16'h0000;
`ifdef SINGLE_STEP_EN
    logic        step = 1'b1;
`endif
    logic        program_counter_increment;
    logic [3:0]  alu_op, alu_a_select, alu_b_select, alu_out_select;
    logic [15:0] alu_a_altern, alu_b_altern, retired;
    logic        alu_a_source, alu_b_source, alu_store_to_mem, alu_store_to_stk, plot, halted;
    logic [1:0]  alu_load_src;
    logic [3:0]  vga_color_select, vga_coord_select;

    int checks = 0;
    int errors = 0;

    // {load_src, increment, store_mem, store_stk, plot, halted}
    wire [6:0]  ctl = {alu_load_src, program_counter_increment, alu_store_to_mem,
                       alu_store_to_stk, plot, halted};
    // {alu_op, a_select, b_select, out_select}
    wire [15:0] sel = {alu_op, alu_a_select, alu_b_select, alu_out_select};

    control_sequencer dut (
        .clock                     (clock),
        .reset                     (reset),
`ifdef SINGLE_STEP_EN
        .step                      (step),
`endif
        .current_instruction       (current_instruction),
        .zeroflag                  (zeroflag),
        .program_counter_increment (program_counter_increment),
        .alu_op                    (alu_op),
        .alu_a_altern              (alu_a_altern),
        .alu_b_altern              (alu_b_altern),
        .alu_a_select              (alu_a_select),
        .alu_b_select              (alu_b_select),
        .alu_a_source              (alu_a_source),
        .alu_b_source              (alu_b_source),
        .alu_out_select            (alu_out_select),
        .alu_load_src              (alu_load_src),
        .alu_store_to_mem          (alu_store_to_mem),
        .alu_store_to_stk          (alu_store_to_stk),
        .vga_color_select          (vga_color_select),
        .vga_coord_select          (vga_coord_select),
        .plot                      (plot),
        .halted                    (halted),
        .retired                   (retired)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (ctl !== 7'b0 || sel !== 16'h0) begin
            errors++; $display("FAIL reset_ctl got %b/%h exp 0/0", ctl, sel);
        end
        checks++;
        if ({alu_a_altern, alu_b_altern, alu_a_source, alu_b_source} !== 34'h0 || retired !== 16'h0) begin
            errors++; $display("FAIL reset_misc got altern %h/%h retired %h exp 0", alu_a_altern,
                               alu_b_altern, retired);
        end
    endtask

    task automatic test_loadi();
        current_instruction = 16'h8305;
        tick();
        checks++;
        if (ctl !== 7'b0110000 || sel !== 16'hF003) begin
            errors++; $display("FAIL loadi_exec got %b/%h exp 0110000/f003", ctl, sel);
        end
        checks++;
        if (alu_a_altern !== 16'h0005 || alu_a_source !== 1'b1 || alu_b_altern !== 16'h0) begin
            errors++; $display("FAIL loadi_imm got %h src %b exp 0005 src 1", alu_a_altern, alu_a_source);
        end
        tick();
        checks++;
        if (ctl !== 7'b0 || retired !== 16'd1) begin
            errors++; $display("FAIL loadi_retire got %b retired %0d exp 0 retired 1", ctl, retired);
        end
    endtask

    task automatic test_load(input logic [15:0] instr, input logic [1:0] src,
                             input logic [15:0] exp_ret);
        current_instruction = instr;
        tick();
        checks++;
        if (ctl !== 7'b0 || sel !== 16'hF102) begin
            errors++; $display("FAIL load_exec got %b/%h exp 0000000/f102", ctl, sel);
        end
        tick();
        checks++;
        if (ctl !== {src, 5'b10000} || sel !== 16'hF102) begin
            errors++; $display("FAIL load_memwait got %b/%h exp %b/f102", ctl, sel, {src, 5'b10000});
        end
        tick();
        checks++;
        if (ctl !== 7'b0 || retired !== exp_ret) begin
            errors++; $display("FAIL load_retire got %b retired %0d exp 0 retired %0d", ctl, retired, exp_ret);
        end
    endtask

    task automatic test_store(input logic [15:0] instr, input logic [6:0] exp_ctl,
                              input logic [15:0] exp_ret);
        current_instruction = instr;
        tick();
        checks++;
        if (ctl !== exp_ctl || sel !== 16'hF104) begin
            errors++; $display("FAIL store_exec got %b/%h exp %b/f104", ctl, sel, exp_ctl);
        end
        tick();
        checks++;
        if (ctl !== 7'b0 || retired !== exp_ret) begin
            errors++; $display("FAIL store_retire got %b retired %0d exp 0 retired %0d", ctl, retired, exp_ret);
        end
    endtask

    task automatic test_brz();
        zeroflag = 16'h0020;
        current_instruction = 16'hD050;
        tick();
        checks++;
        if (ctl !== 7'b0100000 || alu_out_select !== 4'h0 || alu_b_select !== 4'h0) begin
            errors++; $display("FAIL brz_taken got %b/%h exp 0100000 out 0 b 0", ctl, sel);
        end
        tick();
        zeroflag = 16'hFFDF;
        tick();
        checks++;
        if (ctl !== 7'b0010000) begin
            errors++; $display("FAIL brz_not_taken got %b exp 0010000", ctl);
        end
        tick();
        checks++;
        if (retired !== 16'd7) begin
            errors++; $display("FAIL brz_retire got %0d exp 7", retired);
        end
        zeroflag = 16'h0000;
    endtask

    task automatic test_alu();
        current_instruction = 16'h3127;
        tick();
        checks++;
        if (ctl !== 7'b0110000 || sel !== 16'h3271) begin
            errors++; $display("FAIL alu_op3 got %b/%h exp 0110000/3271", ctl, sel);
        end
        tick();
        current_instruction = 16'h7ABC;
        tick();
        checks++;
        if (ctl !== 7'b0110000 || sel !== 16'h7BCA || alu_a_source !== 1'b0) begin
            errors++; $display("FAIL alu_op7 got %b/%h exp 0110000/7bca", ctl, sel);
        end
        tick();
    endtask

    task automatic test_plot();
        current_instruction = 16'hE3A0;
        tick();
        checks++;
        if (ctl !== 7'b0010010 || vga_color_select !== 4'h3 || vga_coord_select !== 4'hA) begin
            errors++; $display("FAIL plot_exec got %b col %h crd %h exp 0010010 col 3 crd a", ctl,
                               vga_color_select, vga_coord_select);
        end
        tick();
        checks++;
        if (ctl !== 7'b0 || retired !== 16'd10) begin
            errors++; $display("FAIL plot_retire got %b retired %0d exp 0 retired 10", ctl, retired);
        end
    endtask

    task automatic test_reset_in_memwait();
        current_instruction = 16'h9210;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (ctl !== 7'b0 || sel !== 16'h0 || retired !== 16'h0) begin
            errors++; $display("FAIL memwait_reset got %b/%h retired %0d exp 0/0 retired 0", ctl, sel, retired);
        end
        current_instruction = 16'h8305;
        tick();
        checks++;
        if (ctl !== 7'b0110000) begin
            errors++; $display("FAIL memwait_refetch got %b exp 0110000", ctl);
        end
        tick();
    endtask

    task automatic test_halt();
        current_instruction = 16'hF000;
        tick();
        checks++;
        if (ctl !== 7'b0) begin
            errors++; $display("FAIL halt_exec got %b exp 0000000", ctl);
        end
        tick();
        checks++;
        if (ctl !== 7'b0000001) begin
            errors++; $display("FAIL halt_state got %b exp 0000001", ctl);
        end
        current_instruction = 16'h8305;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (ctl !== 7'b0000001 || retired !== 16'd1) begin
                errors++; $display("FAIL halt_frozen cycle %0d got %b retired %0d exp 0000001 retired 1",
                                   i, ctl, retired);
            end
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (ctl !== 7'b0 || retired !== 16'd0) begin
            errors++; $display("FAIL halt_reset got %b retired %0d exp 0 retired 0", ctl, retired);
        end
        tick();
        checks++;
        if (ctl !== 7'b0110000) begin
            errors++; $display("FAIL halt_restart got %b exp 0110000", ctl);
        end
        tick();
    endtask

`ifdef SINGLE_STEP_EN
    task automatic test_single_step();
        step = 1'b0;
        current_instruction = 16'h8305;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (ctl !== 7'b0 || retired !== 16'd1) begin
                errors++; $display("FAIL step_hold cycle %0d got %b retired %0d exp 0 retired 1",
                                   i, ctl, retired);
            end
        end
        step = 1'b1;
        tick();
        checks++;
        if (ctl !== 7'b0110000) begin
            errors++; $display("FAIL step_go got %b exp 0110000", ctl);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_loadi();
        test_load(16'h9210, 2'b10, 16'd2);
        test_load(16'hA210, 2'b11, 16'd3);
        test_store(16'hB412, 7'b0011000, 16'd4);
        test_store(16'hC412, 7'b0010100, 16'd5);
        test_brz();
        test_alu();
        test_plot();
        test_reset_in_memwait();
        test_halt();
`ifdef SINGLE_STEP_EN
        test_single_step();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
